// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong game sequencer (serve hold, ball enable, pause, scoring, winner)
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   frame_tick one-cycle pulse per video frame
//   start      debounced start button level (acts on rising edge)
//   pause      debounced pause button level (acts on rising edge)
//   miss_left  ball passed left edge, point to player 2
//   miss_right ball passed right edge, point to player 1
//   ball_hold  ball forced to centre
//   ball_en    ball position may update
//   serve_dir  0 = serve toward right, 1 = toward left
//   score1     player 1 score (saturates at 15)
//   score2     player 2 score (saturates at 15)
//   game_over  high while in OVER
//   winner     0 = player 1, 1 = player 2, valid with game_over
//   state_dbg  current state encoding
module pong_game_ctrl #(
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pause,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_hold,
    output logic       ball_en,
    output logic       serve_dir,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        POINT = 3'd4,
        OVER  = 3'd5
    } state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] score1_n, score2_n;
    logic       serve_dir_n, winner_n;
    logic       start_q, pause_q, armed;
    logic       start_rise, pause_rise;

    // Edges are only recognised once the button has been sampled at least once
    // after reset, so a button held through reset release is not a press.
    assign start_rise = armed & start & ~start_q;
    assign pause_rise = armed & pause & ~pause_q;

    assign ball_hold = (state != PLAY) && (state != PAUSE);
    assign ball_en   = state == PLAY;
    assign game_over = state == OVER;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            score1    <= '0;
            score2    <= '0;
            serve_dir <= 1'b0;
            winner    <= 1'b0;
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            score1    <= score1_n;
            score2    <= score2_n;
            serve_dir <= serve_dir_n;
            winner    <= winner_n;
            start_q   <= start;
            pause_q   <= pause;
            armed     <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        score1_n    = score1;
        score2_n    = score2;
        serve_dir_n = serve_dir;
        winner_n    = winner;
        case (state)
            IDLE, OVER: begin
                if (start_rise) begin
                    state_n     = SERVE;
                    score1_n    = '0;
                    score2_n    = '0;
                    serve_dir_n = 1'b0;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    cnt_n = cnt + 8'd1;
                    if (cnt == 8'(SERVE_FRAMES - 1)) state_n = PLAY;
                end
            end
            PLAY: begin
                // A simultaneous double miss ends the rally without a point.
                if (miss_left || miss_right) begin
                    state_n = POINT;
                    if (miss_left && !miss_right) begin
                        score2_n    = (score2 == 4'd15) ? score2 : score2 + 4'd1;
                        serve_dir_n = 1'b1;
                    end else if (miss_right && !miss_left) begin
                        score1_n    = (score1 == 4'd15) ? score1 : score1 + 4'd1;
                        serve_dir_n = 1'b0;
                    end
                end else if (pause_rise) begin
                    state_n = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_rise) state_n = PLAY;
            end
            POINT: begin
                if (frame_tick) begin
                    cnt_n = cnt + 8'd1;
                    if (cnt == 8'(POINT_FRAMES - 1)) begin
                        if (score1 >= 4'(WIN_SCORE)) begin
                            winner_n = 1'b0;
                            state_n  = OVER;
                        end else if (score2 >= 4'(WIN_SCORE)) begin
                            winner_n = 1'b1;
                            state_n  = OVER;
                        end else begin
                            state_n = SERVE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (state_n != state) cnt_n = '0;
    end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed self-checking bench for pong_game_ctrl
module tb_pong_game_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       ball_hold, ball_en, serve_dir, game_over, winner;
    logic [3:0] score1, score2;
    logic [2:0] state_dbg;
    int         checks = 0;
    int         failures = 0;

    pong_game_ctrl #(.SERVE_FRAMES(2), .POINT_FRAMES(3), .WIN_SCORE(2)) dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .start(start),
        .pause(pause),
        .miss_left(miss_left),
        .miss_right(miss_right),
        .ball_hold(ball_hold),
        .ball_en(ball_en),
        .serve_dir(serve_dir),
        .score1(score1),
        .score2(score2),
        .game_over(game_over),
        .winner(winner),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
    endtask

    task automatic press_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    initial begin
        #12;
        chk("rst_state", state_dbg, 0);
        chk("rst_hold", ball_hold, 1);
        chk("rst_en", ball_en, 0);
        chk("rst_over", game_over, 0);
        chk("rst_s1", score1, 0);
        chk("rst_dir", serve_dir, 0);
        reset = 1'b0;
        repeat (3) tick();
        chk("idle_level", state_dbg, 0);
        start = 1'b1;
        tick();
        chk("start_state", state_dbg, 1);
        chk("serve_hold", ball_hold, 1);
        chk("serve_en", ball_en, 0);
        start = 1'b0;
        tick();
        frame();
        chk("serve_1tick", state_dbg, 1);
        frame();
        chk("play_state", state_dbg, 2);
        chk("play_en", ball_en, 1);
        chk("play_hold", ball_hold, 0);
        miss_right = 1'b1;
        tick();
        miss_right = 1'b0;
        chk("mr_s1", score1, 1);
        chk("mr_dir", serve_dir, 0);
        chk("mr_state", state_dbg, 4);
        tick();
        frame();
        frame();
        chk("point_2tick", state_dbg, 4);
        frame();
        chk("point_done", state_dbg, 1);
        frame();
        frame();
        miss_left = 1'b1;
        tick();
        miss_left = 1'b0;
        chk("ml_s2", score2, 1);
        chk("ml_dir", serve_dir, 1);
        repeat (3) frame();
        chk("tie_serve", state_dbg, 1);
        frame();
        frame();
        miss_left = 1'b1;
        tick();
        miss_left = 1'b0;
        chk("win_s2", score2, 2);
        repeat (3) frame();
        chk("over_state", state_dbg, 5);
        chk("over_flag", game_over, 1);
        chk("over_winner", winner, 1);
        chk("over_hold", ball_hold, 1);
        miss_left = 1'b1;
        tick();
        miss_left = 1'b0;
        chk("over_frozen", score2, 2);
        chk("over_stay", state_dbg, 5);
        press_start();
        chk("restart_state", state_dbg, 1);
        chk("restart_s1", score1, 0);
        chk("restart_s2", score2, 0);
        chk("restart_over", game_over, 0);
        frame();
        frame();
        miss_left = 1'b1;
        tick();
        miss_left = 1'b0;
        chk("g2_ml_dir", serve_dir, 1);
        repeat (3) frame();
        frame();
        frame();
        miss_left = 1'b1;
        miss_right = 1'b1;
        tick();
        miss_left = 1'b0;
        miss_right = 1'b0;
        chk("both_state", state_dbg, 4);
        chk("both_s1", score1, 0);
        chk("both_s2", score2, 1);
        chk("both_dir", serve_dir, 1);
        repeat (3) frame();
        frame();
        frame();
        chk("g2_play", state_dbg, 2);
        pause = 1'b1;
        tick();
        chk("pause_state", state_dbg, 3);
        chk("pause_en", ball_en, 0);
        chk("pause_hold", ball_hold, 0);
        for (int i = 0; i < 100; i++) begin
            frame_tick = (i % 4) == 0;
            tick();
        end
        frame_tick = 1'b0;
        chk("pause_held", state_dbg, 3);
        miss_left = 1'b1;
        tick();
        miss_left = 1'b0;
        chk("pause_miss_s2", score2, 1);
        chk("pause_miss_state", state_dbg, 3);
        pause = 1'b0;
        tick();
        pause = 1'b1;
        tick();
        chk("resume_state", state_dbg, 2);
        pause = 1'b0;
        tick();
        press_start();
        chk("play_start_ign", state_dbg, 2);
        miss_right = 1'b1;
        pause = 1'b1;
        tick();
        miss_right = 1'b0;
        pause = 1'b0;
        chk("miss_pause_state", state_dbg, 4);
        chk("miss_pause_s1", score1, 1);
        frame();
        #2;
        reset = 1'b1;
        #1;
        chk("async_state", state_dbg, 0);
        chk("async_s1", score1, 0);
        chk("async_s2", score2, 0);
        chk("async_hold", ball_hold, 1);
        chk("async_dir", serve_dir, 0);
        start = 1'b1;
        #3;
        reset = 1'b0;
        repeat (3) tick();
        chk("held_start", state_dbg, 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("repress_start", state_dbg, 1);
        start = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
